dmem_arbiter: RTL and testbench

Two-requester arbiter sharing the single data-memory port (word address, 32-bit data, 4-bit byte write enables, combinational read, write on clock edge) between the CPU load/store path (port 0) and a host/loader port (port 1). It grants at most one access per cycle using round-robin priority, returns read data registered one cycle later, and optionally supports a bounded lock for atomic read-modify-write sequences.

---
 rtl/dmem_arb_pkg.sv | 16 +
 rtl/dmem_arb_rr2.sv | 24 ++
 rtl/dmem_arbiter.sv | 176 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: state encoding, port
// indices and the default lock limit.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_t;

  localparam int unsigned PORT_CPU  = 0;
  localparam int unsigned PORT_HOST = 1;

  localparam int unsigned MAX_LOCK_DEFAULT = 15;

endpackage

// File: rtl/dmem_arb_rr2.sv
// Two-input round-robin picker. A masked-off request is never granted; on a
// conflict the port that was not granted last wins.
module dmem_arb_rr2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic [1:0] mask,
  output logic [1:0] gnt
);

  logic [1:0] eligible;

  // Pick at most one eligible requester, favouring the port != last.
  always_comb begin
    eligible = req & mask;
    gnt      = '0;
    case (eligible)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last ? 2'b01 : 2'b10;
      default: gnt = '0;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter sharing one data-memory port between the CPU (port 0) and the
// host/loader (port 1). Round-robin grant, one-cycle registered read return.
// Optional bounded lock for atomic read-modify-write: DMEM_ARB_LOCK_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned AW       = 32,
  parameter int unsigned DW       = 32,
  parameter int unsigned MAX_LOCK = MAX_LOCK_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic [AW-1:0]     m0_addr,
  input  logic [DW-1:0]     m0_wdata,
  input  logic [DW/8-1:0]   m0_we,
  input  logic              m0_lock,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DW-1:0]     m0_rdata,
  input  logic              m1_req,
  input  logic [AW-1:0]     m1_addr,
  input  logic [DW-1:0]     m1_wdata,
  input  logic [DW/8-1:0]   m1_we,
  input  logic              m1_lock,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DW-1:0]     m1_rdata,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  output logic [DW/8-1:0]   mem_we,
  input  logic [DW-1:0]     mem_rdata
);

  logic [1:0] req;
  logic [1:0] gnt;
  logic [1:0] mask;
  logic       last;

  assign req    = {m1_req, m0_req};
  assign m0_gnt = gnt[PORT_CPU];
  assign m1_gnt = gnt[PORT_HOST];

  dmem_arb_rr2 u_rr2 (
    .req  (req),
    .last (last),
    .mask (mask),
    .gnt  (gnt)
  );

`ifdef DMEM_ARB_LOCK_EN
  localparam logic [3:0] LOCK_LIMIT = 4'(MAX_LOCK);

  arb_state_t state, state_next;
  logic [3:0] lock_cnt, lock_cnt_next;

  // Lock state and consecutive-grant counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      lock_cnt <= '0;
    end else begin
      state    <= state_next;
      lock_cnt <= lock_cnt_next;
    end
  end

  // Eligibility mask from lock owner; nothing is eligible during reset.
  always_comb begin
    mask = 2'b11;
    case (state)
      LOCK0:   mask = 2'b01;
      LOCK1:   mask = 2'b10;
      default: mask = 2'b11;
    endcase
    if (reset) mask = '0;
  end

  // Lock entry/exit. lock_cnt counts locked grants including the current
  // one, so the owner gets at most MAX_LOCK consecutive grants.
  always_comb begin
    state_next    = state;
    lock_cnt_next = lock_cnt;
    case (state)
      IDLE: begin
        if (gnt[PORT_CPU] && m0_lock) begin
          state_next    = LOCK0;
          lock_cnt_next = 4'd1;
        end else if (gnt[PORT_HOST] && m1_lock) begin
          state_next    = LOCK1;
          lock_cnt_next = 4'd1;
        end
      end
      LOCK0: begin
        if (!m0_req) begin
          state_next    = IDLE;
          lock_cnt_next = '0;
        end else begin
          lock_cnt_next = lock_cnt + 4'd1;
          if (!m0_lock || lock_cnt_next == LOCK_LIMIT) begin
            state_next    = IDLE;
            lock_cnt_next = '0;
          end
        end
      end
      LOCK1: begin
        if (!m1_req) begin
          state_next    = IDLE;
          lock_cnt_next = '0;
        end else begin
          lock_cnt_next = lock_cnt + 4'd1;
          if (!m1_lock || lock_cnt_next == LOCK_LIMIT) begin
            state_next    = IDLE;
            lock_cnt_next = '0;
          end
        end
      end
      default: begin
        state_next    = IDLE;
        lock_cnt_next = '0;
      end
    endcase
  end
`else
  logic lock_unused;
  assign lock_unused = m0_lock ^ m1_lock;

  // Plain round-robin every cycle; nothing is eligible during reset.
  always_comb begin
    mask = reset ? 2'b00 : 2'b11;
  end
`endif

  // Round-robin pointer: index of the most recently granted port.
  always_ff @(posedge clk) begin
    if (reset) begin
      last <= 1'b1;
    end else if (gnt[PORT_CPU]) begin
      last <= 1'b0;
    end else if (gnt[PORT_HOST]) begin
      last <= 1'b1;
    end
  end

  // Route the granted port onto the memory bus; idle bus is all zero.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = '0;
    if (gnt[PORT_CPU]) begin
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
      mem_we    = m0_we;
    end else if (gnt[PORT_HOST]) begin
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
      mem_we    = m1_we;
    end
  end

  // Capture read data for the granted reader; rdata holds until next read.
  always_ff @(posedge clk) begin
    if (reset) begin
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
    end else begin
      m0_rvalid <= gnt[PORT_CPU] && (m0_we == '0);
      m1_rvalid <= gnt[PORT_HOST] && (m1_we == '0);
      if (gnt[PORT_CPU] && (m0_we == '0)) m0_rdata <= mem_rdata;
      if (gnt[PORT_HOST] && (m1_we == '0)) m1_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a behavioural memory and a
// rule-level arbitration model. Lock scenarios follow DMEM_ARB_LOCK_EN.
module tb_dmem_arbiter;

  localparam int MAXL = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m1_req, m0_lock, m1_lock;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [3:0]  m0_we, m1_we;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_we;

  logic [31:0] tbmem [0:255];

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  int          m_last, m_owner, m_cnt;
  logic [31:0] ref_mem [0:255];
  logic [31:0] exp_rd [2];
  logic        exp_rv [2];
  logic [31:0] exp_addr, exp_wdata;
  logic [3:0]  exp_we;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(32), .DW(32), .MAX_LOCK(MAXL)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_we(m0_we),
    .m0_lock(m0_lock), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_we(m1_we),
    .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] seed_word(int unsigned i);
    if (i == 4) return 32'hDEADBEEF;
    return (i * 32'h9E3779B9) ^ 32'h5A5A0F0F;
  endfunction

  // Behavioural data memory: combinational read, byte-enabled write at edge.
  assign mem_rdata = tbmem[mem_addr[9:2]];
  initial begin
    for (int i = 0; i < 256; i++) tbmem[i] = seed_word(i);
    forever begin
      @(posedge clk);
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) tbmem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic model_reset();
    m_last = 1; m_owner = -1; m_cnt = 0;
    exp_rd[0] = '0; exp_rd[1] = '0;
  endtask

  function automatic int model_pick(logic [1:0] rq);
    if (m_owner >= 0) return rq[m_owner] ? m_owner : -1;
    if (rq == 2'b11) return 1 - m_last;
    if (rq[0]) return 0;
    if (rq[1]) return 1;
    return -1;
  endfunction

  // Predict this cycle's grant from the current inputs and advance the model.
  task automatic model_step(output int g);
    logic [1:0]  rq, lk;
    logic [31:0] ad [2];
    logic [31:0] wd [2];
    logic [3:0]  we [2];
    rq = {m1_req, m0_req}; lk = {m1_lock, m0_lock};
    ad[0] = m0_addr; ad[1] = m1_addr;
    wd[0] = m0_wdata; wd[1] = m1_wdata;
    we[0] = m0_we; we[1] = m1_we;
    exp_rv[0] = 1'b0; exp_rv[1] = 1'b0;
    exp_addr = '0; exp_wdata = '0; exp_we = '0;
    if (reset) begin
      model_reset();
      g = -1;
      return;
    end
    g = model_pick(rq);
    if (g >= 0) begin
      exp_addr = ad[g]; exp_wdata = wd[g]; exp_we = we[g];
      if (we[g] == 4'h0) begin
        exp_rv[g] = 1'b1;
        exp_rd[g] = ref_mem[ad[g][9:2]];
      end else begin
        for (int b = 0; b < 4; b++)
          if (we[g][b]) ref_mem[ad[g][9:2]][8*b +: 8] = wd[g][8*b +: 8];
      end
      m_last = g;
    end
`ifdef DMEM_ARB_LOCK_EN
    if (m_owner < 0) begin
      if (g >= 0 && lk[g]) begin m_owner = g; m_cnt = 1; end
    end else if (!rq[m_owner]) begin
      m_owner = -1;
    end else begin
      m_cnt++;
      if (!lk[m_owner] || m_cnt == MAXL) m_owner = -1;
    end
`endif
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_req = 0; m0_addr = '0; m0_wdata = '0; m0_we = '0; m0_lock = 0;
    m1_req = 0; m1_addr = '0; m1_wdata = '0; m1_we = '0; m1_lock = 0;
  endtask

  task automatic do_reset();
    int g;
    reset = 1; idle_inputs();
    repeat (2) begin @(negedge clk); model_step(g); next_cycle(); end
    reset = 0;
  endtask

  task automatic test_reset();
    int g;
    reset = 1;
    m0_req = 1; m0_addr = 32'h10; m0_we = 4'hF; m0_wdata = 32'h1234;
    m1_req = 1; m1_addr = 32'h14;
    repeat (2) begin
      @(negedge clk); model_step(g);
      n_checks++; if ({m1_gnt, m0_gnt} !== 2'b00) begin n_fail++; $display("FAIL reset_gnt: got %b expected 00", {m1_gnt, m0_gnt}); end
      n_checks++; if (mem_we !== 4'h0) begin n_fail++; $display("FAIL reset_mem_we: got %h expected 0", mem_we); end
      next_cycle();
    end
    n_checks++; if ({m1_rvalid, m0_rvalid} !== 2'b00) begin n_fail++; $display("FAIL reset_rvalid: got %b expected 00", {m1_rvalid, m0_rvalid}); end
    n_checks++; if (m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h/%h expected 0/0", m0_rdata, m1_rdata); end
    idle_inputs(); reset = 0;
  endtask

  task automatic test_single_read();
    int g;
    m0_req = 1; m0_addr = 32'h10;
    @(negedge clk); model_step(g);
    n_checks++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin n_fail++; $display("FAIL single_gnt: got %b%b expected 01", m1_gnt, m0_gnt); end
    n_checks++; if (mem_addr !== 32'h10) begin n_fail++; $display("FAIL single_addr: got %h expected 10", mem_addr); end
    next_cycle();
    n_checks++; if (m0_rvalid !== 1'b1 || m1_rvalid !== 1'b0) begin n_fail++; $display("FAIL single_rvalid: got %b%b expected 01", m1_rvalid, m0_rvalid); end
    n_checks++; if (m0_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_rdata: got %h expected deadbeef", m0_rdata); end
    idle_inputs();
    @(negedge clk); model_step(g);
    next_cycle();
    n_checks++; if (m0_rvalid !== 1'b0) begin n_fail++; $display("FAIL single_pulse: got %b expected 0", m0_rvalid); end
    n_checks++; if (m0_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_hold: got %h expected deadbeef", m0_rdata); end
  endtask

  task automatic test_round_robin();
    int g;
    do_reset();
    m0_req = 1; m0_addr = 32'h40; m1_req = 1; m1_addr = 32'h44;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); model_step(g);
      n_checks++; if (m0_gnt !== (i % 2 == 0) || m1_gnt !== (i % 2 == 1)) begin n_fail++; $display("FAIL rr_gnt[%0d]: got %b%b expected port %0d", i, m1_gnt, m0_gnt, i % 2); end
      next_cycle();
      n_checks++; if (m0_rvalid !== exp_rv[0] || m1_rvalid !== exp_rv[1] || m0_rdata !== exp_rd[0] || m1_rdata !== exp_rd[1]) begin
        n_fail++; $display("FAIL rr_read[%0d]: got %b%b %h/%h expected %b%b %h/%h", i, m1_rvalid, m0_rvalid, m0_rdata, m1_rdata, exp_rv[1], exp_rv[0], exp_rd[0], exp_rd[1]);
      end
    end
    idle_inputs();
  endtask

  task automatic test_write_read();
    int g;
    logic [31:0] wv [2];
    logic [3:0]  wb [2];
    logic [31:0] rv [2];
    wv[0] = 32'hCAFEF00D; wb[0] = 4'b1111; rv[0] = 32'hCAFEF00D;
    wv[1] = 32'h000000AA; wb[1] = 4'b0001; rv[1] = 32'hCAFEF0AA;
    for (int k = 0; k < 2; k++) begin
      idle_inputs();
      m1_req = 1; m1_addr = 32'h20; m1_wdata = wv[k]; m1_we = wb[k];
      @(negedge clk); model_step(g);
      n_checks++; if (m1_gnt !== 1'b1 || mem_we !== wb[k] || mem_wdata !== wv[k]) begin n_fail++; $display("FAIL wr_bus[%0d]: got gnt=%b we=%h wd=%h expected 1 %h %h", k, m1_gnt, mem_we, mem_wdata, wb[k], wv[k]); end
      next_cycle();
      n_checks++; if (m1_rvalid !== 1'b0) begin n_fail++; $display("FAIL wr_no_rvalid[%0d]: got %b expected 0", k, m1_rvalid); end
      idle_inputs();
      m0_req = 1; m0_addr = 32'h20;
      @(negedge clk); model_step(g);
      next_cycle();
      n_checks++; if (m0_rvalid !== 1'b1 || m0_rdata !== rv[k] || exp_rd[0] !== rv[k]) begin n_fail++; $display("FAIL wr_readback[%0d]: got %b %h expected 1 %h", k, m0_rvalid, m0_rdata, rv[k]); end
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    int g;
    m0_req = 1;
    for (int i = 0; i < 4; i++) begin
      m0_addr = 32'h10 + 32'(i) * 32'h10;
      @(negedge clk); model_step(g);
      next_cycle();
      n_checks++; if (m0_rvalid !== 1'b1 || m0_rdata !== exp_rd[0]) begin n_fail++; $display("FAIL b2b[%0d]: got %b %h expected 1 %h", i, m0_rvalid, m0_rdata, exp_rd[0]); end
    end
    idle_inputs();
  endtask

`ifdef DMEM_ARB_LOCK_EN
  task automatic test_lock_release();
    int g;
    do_reset();
    m0_req = 1; m0_addr = 32'h08; m1_req = 1; m1_addr = 32'h0C;
    for (int i = 0; i < 5; i++) begin
      m0_lock = (i < 3);
      @(negedge clk); model_step(g);
      n_checks++; if (m0_gnt !== (i < 4) || m1_gnt !== (i == 4)) begin n_fail++; $display("FAIL lock_rel[%0d]: got %b%b expected %b%b", i, m1_gnt, m0_gnt, i == 4, i < 4); end
      next_cycle();
    end
    idle_inputs();
  endtask

  task automatic test_forced_release();
    int g;
    do_reset();
    m0_req = 1; m0_lock = 1; m0_addr = 32'h18; m1_req = 1; m1_addr = 32'h1C;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); model_step(g);
      n_checks++; if (m0_gnt !== (i < 15) || m1_gnt !== (i == 15)) begin n_fail++; $display("FAIL forced_rel[%0d]: got %b%b expected %b%b", i, m1_gnt, m0_gnt, i == 15, i < 15); end
      next_cycle();
    end
    idle_inputs();
  endtask
`else
  task automatic test_lock_ignored();
    int g;
    do_reset();
    m0_req = 1; m0_lock = 1; m0_addr = 32'h18; m1_req = 1; m1_lock = 1; m1_addr = 32'h1C;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); model_step(g);
      n_checks++; if (m0_gnt !== (i % 2 == 0) || m1_gnt !== (i % 2 == 1)) begin n_fail++; $display("FAIL lock_ignored[%0d]: got %b%b expected port %0d", i, m1_gnt, m0_gnt, i % 2); end
      next_cycle();
    end
    idle_inputs();
  endtask
`endif

  task automatic test_reset_mid_lock();
    int g;
    do_reset();
    m1_req = 1; m1_lock = 1; m1_addr = 32'h24;
    @(negedge clk); model_step(g);
    n_checks++; if (m1_gnt !== 1'b1) begin n_fail++; $display("FAIL rml_enter: got %b expected 1", m1_gnt); end
    next_cycle();
    n_checks++; if (m1_rvalid !== 1'b1) begin n_fail++; $display("FAIL rml_first_read: got %b expected 1", m1_rvalid); end
    reset = 1; m0_req = 1; m0_we = 4'hF; m0_wdata = 32'h55AA55AA; m0_addr = 32'h28;
    @(negedge clk); model_step(g);
    n_checks++; if ({m1_gnt, m0_gnt} !== 2'b00 || mem_we !== 4'h0) begin n_fail++; $display("FAIL rml_in_reset: got gnt=%b%b we=%h expected 00 0", m1_gnt, m0_gnt, mem_we); end
    next_cycle();
    n_checks++; if (m1_rvalid !== 1'b0 || m1_rdata !== 32'h0) begin n_fail++; $display("FAIL rml_suppress: got %b %h expected 0 0", m1_rvalid, m1_rdata); end
    reset = 0; idle_inputs();
    m0_req = 1; m0_addr = 32'h2C; m1_req = 1; m1_addr = 32'h30;
    @(negedge clk); model_step(g);
    n_checks++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin n_fail++; $display("FAIL rml_first_conflict: got %b%b expected 01", m1_gnt, m0_gnt); end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_random();
    int g;
    for (int i = 0; i < 500; i++) begin
      reset    = ($urandom_range(0, 59) == 0);
      m0_req   = $urandom_range(0, 3) != 0;
      m1_req   = $urandom_range(0, 3) != 0;
      m0_lock  = $urandom_range(0, 2) == 0;
      m1_lock  = $urandom_range(0, 2) == 0;
      m0_addr  = 32'($urandom_range(0, 15)) << 2;
      m1_addr  = 32'($urandom_range(0, 15)) << 2;
      m0_wdata = $urandom; m1_wdata = $urandom;
      m0_we    = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      m1_we    = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      @(negedge clk); model_step(g);
      n_checks++; if (m0_gnt !== (g == 0) || m1_gnt !== (g == 1)) begin n_fail++; $display("FAIL rnd_gnt[%0d]: got %b%b expected grant %0d", i, m1_gnt, m0_gnt, g); end
      n_checks++; if (mem_addr !== exp_addr || mem_we !== exp_we || mem_wdata !== exp_wdata) begin
        n_fail++; $display("FAIL rnd_bus[%0d]: got %h %h %h expected %h %h %h", i, mem_addr, mem_we, mem_wdata, exp_addr, exp_we, exp_wdata);
      end
      next_cycle();
      n_checks++; if (m0_rvalid !== exp_rv[0] || m1_rvalid !== exp_rv[1]) begin n_fail++; $display("FAIL rnd_rvalid[%0d]: got %b%b expected %b%b", i, m1_rvalid, m0_rvalid, exp_rv[1], exp_rv[0]); end
      n_checks++; if (m0_rdata !== exp_rd[0] || m1_rdata !== exp_rd[1]) begin n_fail++; $display("FAIL rnd_rdata[%0d]: got %h/%h expected %h/%h", i, m0_rdata, m1_rdata, exp_rd[0], exp_rd[1]); end
    end
    reset = 0; idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = seed_word(i);
    model_reset();
    reset = 1; idle_inputs();
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_read();
    test_back_to_back();
`ifdef DMEM_ARB_LOCK_EN
    test_lock_release();
    test_forced_release();
`else
    test_lock_ignored();
`endif
    test_reset_mid_lock();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
